div_issue_ctrl: RTL and testbench



---
 rtl/div_issue_ctrl_pkg.sv | 22 ++
 rtl/div_result_cache.sv | 49 ++++
 rtl/div_issue_ctrl.sv | 148 ++++++++++++++
 tb/tb_div_issue_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/div_issue_ctrl_pkg.sv
// Shared types and constants for the divider issue controller.
package div_issue_ctrl_pkg;

  localparam int DIV_XLEN       = 32;
  localparam int DIV_REG_ADDR_W = 5;

  localparam int OP_DIV  = 3;
  localparam int OP_DIVU = 2;
  localparam int OP_REM  = 1;
  localparam int OP_REMU = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_WB   = 2'd2
  } div_state_e;

  function automatic logic op_is_divide(input logic [3:0] op);
    return op[OP_DIV] | op[OP_DIVU] | op[OP_REM] | op[OP_REMU];
  endfunction

endpackage

// File: rtl/div_result_cache.sv
// One-entry cache of the last completed divide; lookup is an exact match on op and operands.
module div_result_cache
  import div_issue_ctrl_pkg::*;
#(
  parameter int XLEN = DIV_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [3:0]      wr_op,
  input  logic [XLEN-1:0] wr_dividend,
  input  logic [XLEN-1:0] wr_divisor,
  input  logic [XLEN-1:0] wr_result,
  input  logic [3:0]      lk_op,
  input  logic [XLEN-1:0] lk_dividend,
  input  logic [XLEN-1:0] lk_divisor,
  output logic            hit,
  output logic [XLEN-1:0] hit_result
);

  logic            valid_r;
  logic [3:0]      op_r;
  logic [XLEN-1:0] dividend_r;
  logic [XLEN-1:0] divisor_r;
  logic [XLEN-1:0] result_r;

  // Entry storage; a flush never reaches here, only reset drops the entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r    <= 1'b0;
      op_r       <= 4'b0000;
      dividend_r <= {XLEN{1'b0}};
      divisor_r  <= {XLEN{1'b0}};
      result_r   <= {XLEN{1'b0}};
    end else if (wr_en) begin
      valid_r    <= 1'b1;
      op_r       <= wr_op;
      dividend_r <= wr_dividend;
      divisor_r  <= wr_divisor;
      result_r   <= wr_result;
    end else begin
      valid_r    <= valid_r;
    end
  end

  assign hit        = valid_r & (op_r == lk_op) & (dividend_r == lk_dividend) & (divisor_r == lk_divisor);
  assign hit_result = result_r;

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue/stall/writeback control in front of the iterative divider.
// Define DIV_RESULT_CACHE_EN to add a one-entry result cache that bypasses the divider on repeats.
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = DIV_REG_ADDR_W,
  parameter int XLEN       = DIV_XLEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  input  logic [3:0]            op_i,
  input  logic [XLEN-1:0]       dividend_i,
  input  logic [XLEN-1:0]       divisor_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic                  flush_i,
  output logic                  div_start_o,
  output logic [3:0]            div_op_o,
  output logic [XLEN-1:0]       div_dividend_o,
  output logic [XLEN-1:0]       div_divisor_o,
  input  logic [XLEN-1:0]       div_result_i,
  input  logic                  div_ready_i,
  output logic                  hold_o,
  output logic                  busy_o,
  output logic                  wb_we_o,
  output logic [REG_ADDR_W-1:0] wb_addr_o,
  output logic [XLEN-1:0]       wb_data_o
);

  div_state_e            state_r;
  logic                  start_r;
  logic [3:0]            op_r;
  logic [XLEN-1:0]       dividend_r;
  logic [XLEN-1:0]       divisor_r;
  logic [REG_ADDR_W-1:0] rd_r;
  logic                  wb_we_r;
  logic [REG_ADDR_W-1:0] wb_addr_r;
  logic [XLEN-1:0]       wb_data_r;
  logic                  accept_s;
  logic                  hit_s;
  logic [XLEN-1:0]       hit_result_s;

  assign accept_s = (state_r == ST_IDLE) & req_valid_i & op_is_divide(op_i) & ~flush_i;

`ifdef DIV_RESULT_CACHE_EN
  logic cache_wr_s;
  assign cache_wr_s = (state_r == ST_BUSY) & ~flush_i & div_ready_i;

  div_result_cache #(.XLEN(XLEN)) u_cache (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (cache_wr_s),
    .wr_op       (op_r),
    .wr_dividend (dividend_r),
    .wr_divisor  (divisor_r),
    .wr_result   (div_result_i),
    .lk_op       (op_i),
    .lk_dividend (dividend_i),
    .lk_divisor  (divisor_i),
    .hit         (hit_s),
    .hit_result  (hit_result_s)
  );
`else
  assign hit_s        = 1'b0;
  assign hit_result_s = {XLEN{1'b0}};
`endif

  // Controller FSM; divider-facing registers are zero whenever the FSM is not in BUSY.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      start_r    <= 1'b0;
      op_r       <= 4'b0000;
      dividend_r <= {XLEN{1'b0}};
      divisor_r  <= {XLEN{1'b0}};
      rd_r       <= {REG_ADDR_W{1'b0}};
      wb_we_r    <= 1'b0;
      wb_addr_r  <= {REG_ADDR_W{1'b0}};
      wb_data_r  <= {XLEN{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          wb_we_r <= 1'b0;
          if (accept_s && hit_s) begin
            state_r   <= ST_WB;
            wb_we_r   <= (rd_addr_i != {REG_ADDR_W{1'b0}});
            wb_addr_r <= rd_addr_i;
            wb_data_r <= hit_result_s;
          end else if (accept_s) begin
            state_r    <= ST_BUSY;
            start_r    <= 1'b1;
            op_r       <= op_i;
            dividend_r <= dividend_i;
            divisor_r  <= divisor_i;
            rd_r       <= rd_addr_i;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (flush_i || div_ready_i) begin
            start_r    <= 1'b0;
            op_r       <= 4'b0000;
            dividend_r <= {XLEN{1'b0}};
            divisor_r  <= {XLEN{1'b0}};
          end else begin
            start_r <= 1'b1;
          end
          // Flush wins over a coincident ready: the result is dropped.
          if (flush_i) begin
            state_r <= ST_IDLE;
          end else if (div_ready_i) begin
            state_r   <= ST_WB;
            wb_we_r   <= (rd_r != {REG_ADDR_W{1'b0}});
            wb_addr_r <= rd_r;
            wb_data_r <= div_result_i;
          end else begin
            state_r <= ST_BUSY;
          end
        end
        ST_WB: begin
          state_r <= ST_IDLE;
          wb_we_r <= 1'b0;
        end
        default: begin
          state_r    <= ST_IDLE;
          start_r    <= 1'b0;
          op_r       <= 4'b0000;
          dividend_r <= {XLEN{1'b0}};
          divisor_r  <= {XLEN{1'b0}};
          wb_we_r    <= 1'b0;
        end
      endcase
    end
  end

  // Start drops in the ready cycle so the divider cannot restart, and on flush to abort it.
  assign div_start_o    = start_r & ~div_ready_i & ~flush_i;
  assign div_op_o       = op_r;
  assign div_dividend_o = dividend_r;
  assign div_divisor_o  = divisor_r;
  assign hold_o         = ((state_r == ST_IDLE) & req_valid_i & ~flush_i) | (state_r == ST_BUSY);
  assign busy_o         = (state_r == ST_BUSY);
  assign wb_we_o        = wb_we_r;
  assign wb_addr_o      = wb_addr_r;
  assign wb_data_o      = wb_data_r;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: divider environment, transaction-level reference model and directed tests.
module tb_div_issue_ctrl;

`ifdef DIV_RESULT_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, req_valid, flush, div_ready;
  logic [3:0]  op;
  logic [31:0] dividend, divisor, div_result;
  logic [4:0]  rd_addr;
  logic        div_start, hold_o, busy_o, wb_we_o;
  logic [3:0]  div_op;
  logic [31:0] div_dividend, div_divisor, wb_data_o;
  logic [4:0]  wb_addr_o;

  always #5 clk = ~clk;

  div_issue_ctrl dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .op_i(op),
    .dividend_i(dividend), .divisor_i(divisor), .rd_addr_i(rd_addr), .flush_i(flush),
    .div_start_o(div_start), .div_op_o(div_op), .div_dividend_o(div_dividend),
    .div_divisor_o(div_divisor), .div_result_i(div_result), .div_ready_i(div_ready),
    .hold_o(hold_o), .busy_o(busy_o), .wb_we_o(wb_we_o), .wb_addr_o(wb_addr_o),
    .wb_data_o(wb_data_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // RISC-V M-extension divide semantics, used by both the divider stand-in and the model.
  function automatic logic [31:0] ref_div(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    bit ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      4'b1000: return (b == 32'd0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
      4'b0100: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      4'b0010: return (b == 32'd0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
      4'b0001: return (b == 32'd0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  // Transaction-level model state
  bit          m_fly, m_wb;
  logic [3:0]  m_op;
  logic [31:0] m_a, m_b, m_wb_data;
  logic [4:0]  m_rd, m_wb_addr;
  bit          c_v;
  logic [3:0]  c_op;
  logic [31:0] c_a, c_b, c_r;
  // Divider stand-in
  bit          dv_busy;
  int          dv_cnt;
  logic [31:0] dv_res;
  // Per-transaction statistics
  int          hold_cnt, wb_cnt, start_cnt, start_in_ready;
  logic [31:0] last_data;
  logic [4:0]  last_addr;

  // One clock cycle: drive divider, compare every output, advance model and divider.
  task automatic cycle();
    bit e_hold, e_start;
    div_ready  = dv_busy && (dv_cnt == 0);
    div_result = div_ready ? dv_res : 32'hDEAD_BEEF;
    #1;
    e_hold  = m_fly || (!m_wb && req_valid && !flush);
    e_start = m_fly && !div_ready && !flush;
    chk("hold_o", 32'(hold_o), 32'(e_hold));
    chk("busy_o", 32'(busy_o), 32'(m_fly));
    chk("div_start_o", 32'(div_start), 32'(e_start));
    chk("div_op_o", 32'(div_op), m_fly ? 32'(m_op) : 32'd0);
    chk("div_dividend_o", div_dividend, m_fly ? m_a : 32'd0);
    chk("div_divisor_o", div_divisor, m_fly ? m_b : 32'd0);
    chk("wb_we_o", 32'(wb_we_o), 32'(m_wb && (m_wb_addr != 5'd0)));
    chk("wb_addr_o", 32'(wb_addr_o), 32'(m_wb_addr));
    chk("wb_data_o", wb_data_o, m_wb_data);
    if (hold_o) hold_cnt++;
    if (div_start) start_cnt++;
    if (div_start && div_ready) start_in_ready++;
    if (wb_we_o) begin wb_cnt++; last_data = wb_data_o; last_addr = wb_addr_o; end
    if (m_fly) begin
      if (flush) m_fly = 1'b0;
      else if (div_ready) begin
        m_fly = 1'b0; m_wb = 1'b1; m_wb_addr = m_rd; m_wb_data = ref_div(m_op, m_a, m_b);
        c_v = 1'b1; c_op = m_op; c_a = m_a; c_b = m_b; c_r = m_wb_data;
      end
    end else if (m_wb) begin
      m_wb = 1'b0;
    end else if (req_valid && op != 4'd0 && !flush) begin
      if (CACHE && c_v && c_op == op && c_a == dividend && c_b == divisor) begin
        m_wb = 1'b1; m_wb_addr = rd_addr; m_wb_data = c_r;
      end else begin
        m_fly = 1'b1; m_op = op; m_a = dividend; m_b = divisor; m_rd = rd_addr;
      end
    end
    if (dv_busy) begin
      if (div_ready || !div_start) dv_busy = 1'b0;
      else dv_cnt--;
    end else if (div_start) begin
      dv_busy = 1'b1;
      dv_cnt  = (div_divisor == 32'd0) ? 1 : 34;
      dv_res  = ref_div(div_op, div_dividend, div_divisor);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one divide and run it to completion, optionally flushing mid-flight, on ready, or in WB.
  task automatic run_div(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int flush_at, input bit flush_rdy, input bit flush_wb);
    int n;
    hold_cnt = 0; wb_cnt = 0; start_cnt = 0; start_in_ready = 0;
    req_valid = 1'b1; op = o; dividend = a; divisor = b; rd_addr = rd; flush = 1'b0;
    cycle();
    n = 0;
    while (m_fly && n < 200) begin
      flush = (n == flush_at) || (flush_rdy && dv_busy && dv_cnt == 0);
      cycle();
      n++;
    end
    chk("busy_timeout", 32'(m_fly), 32'd0);
    flush = flush_wb;
    if (m_wb) cycle();
    req_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; flush = 1'b0; op = 4'd0; dividend = 32'd0;
    divisor = 32'd0; rd_addr = 5'd0; div_ready = 1'b0; div_result = 32'd0;
    m_fly = 1'b0; m_wb = 1'b0; m_op = 4'd0; m_a = 32'd0; m_b = 32'd0; m_rd = 5'd0;
    m_wb_addr = 5'd0; m_wb_data = 32'd0; c_v = 1'b0; c_op = 4'd0; c_a = 32'd0;
    c_b = 32'd0; c_r = 32'd0; dv_busy = 1'b0; dv_cnt = 0; dv_res = 32'd0;
    last_data = 32'd0; last_addr = 5'd0;
    repeat (3) @(negedge clk);
    chk("rst_hold", 32'(hold_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_start", 32'(div_start), 32'd0);
    chk("rst_we", 32'(wb_we_o), 32'd0);
    chk("rst_addr", 32'(wb_addr_o), 32'd0);
    chk("rst_data", wb_data_o, 32'd0);
    rst = 1'b0;
    cycle();

    run_div(4'b0100, 32'd100, 32'd7, 5'd5, -1, 1'b0, 1'b0);
    chk("divu_wb_cnt", 32'(wb_cnt), 32'd1);
    chk("divu_addr", 32'(last_addr), 32'd5);
    chk("divu_data", last_data, 32'd14);
    chk("divu_hold_cnt", 32'(hold_cnt), 32'd37);
    chk("divu_start_cnt", 32'(start_cnt), 32'd35);
    chk("divu_start_in_ready", 32'(start_in_ready), 32'd0);

    run_div(4'b0010, 32'hFFFF_FFF9, 32'd2, 5'd7, -1, 1'b0, 1'b0);
    chk("rem_neg_data", last_data, 32'hFFFF_FFFF);

    run_div(4'b1000, 32'd1234, 32'd0, 5'd3, -1, 1'b0, 1'b0);
    chk("div0_data", last_data, 32'hFFFF_FFFF);
    chk("div0_hold_cnt", 32'(hold_cnt), 32'd4);

    run_div(4'b0100, 32'd50, 32'd5, 5'd9, 10, 1'b0, 1'b0);
    chk("flush_wb_cnt", 32'(wb_cnt), 32'd0);
    chk("flush_hold_cnt", 32'(hold_cnt), 32'd12);
    cycle();
    run_div(4'b0100, 32'd50, 32'd5, 5'd9, -1, 1'b0, 1'b0);
    chk("after_flush_data", last_data, 32'd10);
    chk("after_flush_wb_cnt", 32'(wb_cnt), 32'd1);

    run_div(4'b1000, 32'd7, 32'd0, 5'd4, -1, 1'b1, 1'b0);
    chk("flush_ready_wb_cnt", 32'(wb_cnt), 32'd0);

    run_div(4'b0100, 32'd9, 32'd3, 5'd0, -1, 1'b0, 1'b0);
    chk("rd0_wb_cnt", 32'(wb_cnt), 32'd0);
    chk("rd0_hold_cnt", 32'(hold_cnt), 32'd37);
    chk("rd0_data_held", wb_data_o, 32'd3);

    run_div(4'b0001, 32'd100, 32'd7, 5'd6, -1, 1'b0, 1'b1);
    chk("flush_in_wb_cnt", 32'(wb_cnt), 32'd1);
    chk("remu_data", last_data, 32'd2);

    run_div(4'b1000, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, -1, 1'b0, 1'b0);
    chk("ovf_data", last_data, 32'h8000_0000);

`ifdef DIV_RESULT_CACHE_EN
    run_div(4'b0100, 32'd100, 32'd7, 5'd10, -1, 1'b0, 1'b0);
    chk("cache_miss_start_cnt", 32'(start_cnt), 32'd35);
    run_div(4'b0100, 32'd100, 32'd7, 5'd11, -1, 1'b0, 1'b0);
    chk("cache_hit_start_cnt", 32'(start_cnt), 32'd0);
    chk("cache_hit_hold_cnt", 32'(hold_cnt), 32'd1);
    chk("cache_hit_data", last_data, 32'd14);
    chk("cache_hit_addr", 32'(last_addr), 32'd11);
    run_div(4'b0100, 32'd100, 32'd8, 5'd12, -1, 1'b0, 1'b0);
    chk("cache_miss2_start_cnt", 32'(start_cnt), 32'd35);
    chk("cache_miss2_data", last_data, 32'd12);
`endif

    repeat (2) cycle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
